// File: rtl/mouse_paddle.sv
// rtl/mouse_paddle.sv - PS/2 mouse packets accumulated into a signed analog joystick axis pair
// Two-stage pipeline (latch/shift, then clamp/accumulate); analog joystick or CPU halt drops back to joystick mode.
module mouse_paddle #(
    parameter int STEP_MAX    = 10,
    parameter int IDLE_CYCLES = 28000000,
    parameter bit INVERT_Y    = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] joya,
    input  logic        cpu_halt,
    input  logic [1:0]  sens,
    output logic [7:0]  ax,
    output logic [7:0]  ay,
    output logic [1:0]  btn,
    output logic        active
);

    typedef enum logic {ST_JOY, ST_MOUSE} state_t;

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [IW:0] IDLE_LIM = (IW+1)'(IDLE_CYCLES);
    localparam logic signed [9:0] STEP_POS = 10'(STEP_MAX);
    localparam logic signed [9:0] STEP_NEG = -STEP_POS;

    state_t state, next_state;
    logic                strobe_q;
    logic                v1;
    logic signed [8:0]   dx1, dy1;
    logic [1:0]          btn1, btn_q;
    logic signed [7:0]   acc_x, acc_y;
    logic [IW-1:0]       idle_cnt;

    logic signed [8:0] raw_dx, raw_dy;
    logic pkt_event, blocked, timeout, kill;

    assign raw_dx    = {ps2_mouse[4], ps2_mouse[15:8]};
    assign raw_dy    = {ps2_mouse[5], ps2_mouse[23:16]};
    assign pkt_event = ps2_mouse[24] ^ strobe_q;
    assign blocked   = (joya != '0) || cpu_halt;
    // Timeout fires on the edge where the counter would reach the limit.
    assign timeout   = (IDLE_CYCLES > 0) && (state == ST_MOUSE) &&
                       (({1'b0, idle_cnt} + (IW+1)'(1)) >= IDLE_LIM);
    assign kill      = blocked || timeout;

    function automatic logic signed [7:0] accum(input logic signed [7:0] acc,
                                                input logic signed [8:0] d,
                                                input logic neg);
        logic signed [9:0] inc;
        logic signed [9:0] sum;
        logic signed [7:0] res;
        inc = {d[8], d};
        if (inc > STEP_POS)
            inc = STEP_POS;
        else if (inc < STEP_NEG)
            inc = STEP_NEG;
        if (neg)
            inc = -inc;
        sum = {{2{acc[7]}}, acc} + inc;
        if (sum > 10'sd127)
            res = 8'h7F;
        else if (sum < -10'sd128)
            res = 8'h80;
        else
            res = sum[7:0];
        return res;
    endfunction

    // Unreset on purpose: clocking through reset tracks the strobe so release sees no event.
    always_ff @(posedge clk_sys)
        strobe_q <= ps2_mouse[24];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            dx1      <= '0;
            dy1      <= '0;
            btn1     <= '0;
            btn_q    <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            idle_cnt <= '0;
        end else begin
            if (kill) begin
                v1   <= 1'b0;
                dx1  <= '0;
                dy1  <= '0;
                btn1 <= '0;
            end else begin
                v1 <= pkt_event;
                if (pkt_event) begin
                    dx1  <= raw_dx >>> sens;
                    dy1  <= raw_dy >>> sens;
                    btn1 <= ps2_mouse[1:0];
                end
            end

            if (kill) begin
                acc_x <= '0;
                acc_y <= '0;
                btn_q <= '0;
            end else if (v1) begin
                acc_x <= accum(acc_x, dx1, 1'b0);
                acc_y <= accum(acc_y, dy1, INVERT_Y);
                btn_q <= btn1;
            end

            if (pkt_event || !(state == ST_MOUSE || v1))
                idle_cnt <= '0;
            else if ({1'b0, idle_cnt} < IDLE_LIM)
                idle_cnt <= idle_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= ST_JOY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (kill)
            next_state = ST_JOY;
        else if (v1)
            next_state = ST_MOUSE;
    end

    always_comb begin
        active = (state == ST_MOUSE);
        ax     = joya[7:0];
        ay     = joya[15:8];
        btn    = 2'b00;
        if (active) begin
            ax  = acc_x;
            ay  = acc_y;
            btn = btn_q;
        end
    end

endmodule
